pipe_adder: RTL and testbench
=============================

# pipe_adder

Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshakes on both sides. It generalises the single-bit full adder (x, y, carry-in to sum, carry-out) to WIDTH bits split across STAGES register slices. It adds a subtract mode, signed-overflow detection and back-pressure. It is the multi-bit arithmetic primitive that DRSynthesis datapaths instantiate in place of hand-chained full adders.

## Interface
- WIDTH, 8, operand/result width in bits; ≥1
- STAGES, 2, pipeline slices; 1 ≤ STAGES ≤ WIDTH, WIDTH % STAGES == 0; slice width S = WIDTH/STAGES
- clock  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts a beat this cycle
- x_in  in  WIDTH  operand X
- y_in  in  WIDTH  operand Y
- c_in  in  1  carry-in (borrow-in when subtracting)
- sub_in  in  1  0 = add, 1 = subtract
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- sum_out  out  WIDTH  result
- cout_out  out  1  carry out of MSB
- ovf_out  out  1  two's-complement overflow

## Operation
- Effective operands: Ye = sub_in ? ~y_in : y_in; Ce = c_in ^ sub_in.
- Result: {cout_out, sum_out} = x_in + Ye + Ce, computed at WIDTH+1 bits with no truncation of the carry.
  - sub_in=1, c_in=0 gives X−Y.
  - sub_in=1, c_in=1 gives X−Y−1.
  - In subtract mode cout_out=1 means no borrow.
- ovf_out = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- Stage k (0..STAGES−1) adds bits [k·S +: S] using the carry registered by stage k−1; stage 0 uses Ce.
- Slices already computed are carried forward in skew registers. Slices not yet reached are carried forward as operands. Result bits therefore all emerge aligned at the last stage.
- Each stage register holds a valid bit. A bubble (valid=0) propagates like data, and its data fields are don't-care.
- Global stall: advance = !out_valid || out_ready. When advance=0, every pipeline register holds, including output data.
- in_ready = advance && !reset. A beat transfers when in_valid && in_ready.
- Output transfer happens when out_valid && out_ready. sum_out, cout_out and ovf_out stay stable while out_valid && !out_ready.
- Ordering is strictly FIFO. There is no reordering and no drop except at reset.

## Timing
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES, given no stall. Each stall cycle adds one cycle.
- Throughput is one beat per cycle when out_ready is held at 1.
- STAGES=1: a single register after a full combinational WIDTH-bit add; latency is 1.
- Reset, checked on the clock edge:
  - All valid bits are 0.
  - out_valid=0, sum_out=0, cout_out=0, ovf_out=0.
  - in_ready is 0 while reset=1 and 1 in the first cycle after reset deasserts.
- Reset mid-stream: all in-flight beats are discarded. No partial result is ever presented.
- Simultaneous output transfer and input accept in the same cycle is legal, and the pipeline shifts by one.
- out_ready=0 with out_valid=0: the pipeline still advances, so bubbles are squeezed at the output stage only.
- Wrap-around: the result is modulo 2^WIDTH, and the carry is reported on cout_out.

## Test plan
- WIDTH=1, STAGES=1, all 8 {x,y,c} combinations with sub_in=0. The result must match the full-adder truth table, e.g. 1+1+1 → sum=1, cout=1, each out_valid exactly 1 cycle after accept.
- WIDTH=8, STAGES=2, add:
  - 0xFF+0x01, c_in=0 → sum=0x00, cout=1, ovf=0.
  - 0x7F+0x01 → sum=0x80, cout=0, ovf=1.
  - Both results appear 2 cycles after accept.
- WIDTH=8, STAGES=4, subtract:
  - 0x05−0x07, c_in=0 → 0xFE, cout=0, ovf=0.
  - 0x80−0x01 → 0x7F, cout=1, ovf=1.
  - 0x10−0x03, c_in=1 → 0x0C, cout=1.
- Streaming plus back-pressure, WIDTH=16, STAGES=4:
  - Send 20 random beats back-to-back and hold out_ready=0 for cycles 6–9.
  - Expect in_ready=0 during the stall, outputs held stable, all 20 results in order and correct against a reference model, with no duplicates.
- Reset mid-stream: assert reset for 1 cycle with 3 beats in flight. Expect out_valid=0 and outputs 0 the next cycle, and none of the 3 beats emitted. A new beat sent after reset returns correctly after STAGES cycles.

Source files
------------

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit ripple-carry adder/subtractor cut into STAGES register slices.
// One global stall enable keeps every slice moving together behind valid/ready handshakes.
module pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic             c_in,
  input  logic             sub_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             ovf_out
);
  localparam int S = WIDTH / STAGES;

  logic advance_s;

  assign advance_s = !out_valid || out_ready;
  assign in_ready  = advance_s && !reset;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * S;
    localparam int REM = WIDTH - LO;

    // acc packs {result bits already summed, carry into the next slice} so bit 0 is always the carry
    logic           v_s;
    logic [LO:0]    acc_s;
    logic [REM-1:0] xa_s;
    logic [REM-1:0] ya_s;
    logic [S:0]     slice_s;
    logic [LO+S:0]  acc_nxt_s;
    logic           v_r;
    logic [LO+S:0]  acc_r;

    if (k == 0) begin : g_src
      assign v_s       = in_valid;
      assign acc_s     = c_in ^ sub_in;
      assign xa_s      = x_in;
      assign ya_s      = sub_in ? ~y_in : y_in;
      assign acc_nxt_s = {slice_s[S-1:0], slice_s[S]};
    end else begin : g_src
      assign v_s       = g_stage[k-1].v_r;
      assign acc_s     = g_stage[k-1].acc_r;
      assign xa_s      = g_stage[k-1].g_ops.x_r;
      assign ya_s      = g_stage[k-1].g_ops.y_r;
      assign acc_nxt_s = {slice_s[S-1:0], acc_s[LO:1], slice_s[S]};
    end

    assign slice_s = {1'b0, xa_s[S-1:0]} + {1'b0, ya_s[S-1:0]} + {{S{1'b0}}, acc_s[0]};

    // Slice register: valid bit plus the partial result and its carry
    always_ff @(posedge clock) begin
      if (reset) begin
        v_r   <= 1'b0;
        acc_r <= {(LO+S+1){1'b0}};
      end else if (advance_s) begin
        v_r   <= v_s;
        acc_r <= acc_nxt_s;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [REM-S-1:0] x_r;
      logic [REM-S-1:0] y_r;

      // Skew register: operand slices not yet reached ride along with the beat
      always_ff @(posedge clock) begin
        if (reset) begin
          x_r <= {(REM-S){1'b0}};
          y_r <= {(REM-S){1'b0}};
        end else if (advance_s) begin
          x_r <= xa_s[REM-1:S];
          y_r <= ya_s[REM-1:S];
        end
      end
    end else begin : g_last
      logic ovf_r;

      // Overflow: carry into the MSB (x^y^sum there) against carry out of the MSB
      always_ff @(posedge clock) begin
        if (reset) begin
          ovf_r <= 1'b0;
        end else if (advance_s) begin
          ovf_r <= xa_s[S-1] ^ ya_s[S-1] ^ slice_s[S-1] ^ slice_s[S];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_r;
  assign sum_out   = g_stage[STAGES-1].acc_r[WIDTH:1];
  assign cout_out  = g_stage[STAGES-1].acc_r[0];
  assign ovf_out   = g_stage[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: four configurations share stimulus; one is selected at a time.
// Expected values come from hand tables and a plain-arithmetic reference model.
module tb_pipe_adder;
  typedef struct {
    int          sel;
    logic [15:0] x;
    logic [15:0] y;
    logic        c;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_x, in_y;
  logic        in_c, in_sub, drv_valid, out_rdy;
  int          sel;
  int          errors = 0;
  int          checks = 0;
  vec_t        tbl[$];
  logic [17:0] exp_q[$];

  logic        v0, v1, v2, v3, r0, r1, r2, r3, ov0, ov1, ov2, ov3;
  logic        co0, co1, co2, co3, of0, of1, of2, of3;
  logic [0:0]  s0;
  logic [7:0]  s1, s2;
  logic [15:0] s3;
  logic        act_valid, act_ready, act_cout, act_ovf;
  logic [15:0] act_sum;

  always #5 clk = ~clk;

  assign v0 = drv_valid && (sel == 0);
  assign v1 = drv_valid && (sel == 1);
  assign v2 = drv_valid && (sel == 2);
  assign v3 = drv_valid && (sel == 3);

  pipe_adder #(.WIDTH(1), .STAGES(1)) u_w1s1 (.clock(clk), .reset(reset), .in_valid(v0), .in_ready(r0),
    .x_in(in_x[0:0]), .y_in(in_y[0:0]), .c_in(in_c), .sub_in(in_sub), .out_valid(ov0),
    .out_ready(out_rdy), .sum_out(s0), .cout_out(co0), .ovf_out(of0));
  pipe_adder #(.WIDTH(8), .STAGES(2)) u_w8s2 (.clock(clk), .reset(reset), .in_valid(v1), .in_ready(r1),
    .x_in(in_x[7:0]), .y_in(in_y[7:0]), .c_in(in_c), .sub_in(in_sub), .out_valid(ov1),
    .out_ready(out_rdy), .sum_out(s1), .cout_out(co1), .ovf_out(of1));
  pipe_adder #(.WIDTH(8), .STAGES(4)) u_w8s4 (.clock(clk), .reset(reset), .in_valid(v2), .in_ready(r2),
    .x_in(in_x[7:0]), .y_in(in_y[7:0]), .c_in(in_c), .sub_in(in_sub), .out_valid(ov2),
    .out_ready(out_rdy), .sum_out(s2), .cout_out(co2), .ovf_out(of2));
  pipe_adder #(.WIDTH(16), .STAGES(4)) u_w16s4 (.clock(clk), .reset(reset), .in_valid(v3), .in_ready(r3),
    .x_in(in_x), .y_in(in_y), .c_in(in_c), .sub_in(in_sub), .out_valid(ov3),
    .out_ready(out_rdy), .sum_out(s3), .cout_out(co3), .ovf_out(of3));

  always_comb begin
    act_valid = 1'b0; act_ready = 1'b0; act_cout = 1'b0; act_ovf = 1'b0; act_sum = 16'h0;
    case (sel)
      0: begin act_valid = ov0; act_ready = r0; act_sum = {15'h0, s0}; act_cout = co0; act_ovf = of0; end
      1: begin act_valid = ov1; act_ready = r1; act_sum = {8'h0, s1};  act_cout = co1; act_ovf = of1; end
      2: begin act_valid = ov2; act_ready = r2; act_sum = {8'h0, s2};  act_cout = co2; act_ovf = of2; end
      3: begin act_valid = ov3; act_ready = r3; act_sum = s3;          act_cout = co3; act_ovf = of3; end
      default: begin act_valid = 1'b0; end
    endcase
  end

  function automatic int width_of(input int s);
    case (s)
      0: return 1;
      1: return 8;
      2: return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int lat_of(input int s);
    case (s)
      0: return 1;
      1: return 2;
      default: return 4;
    endcase
  endfunction

  // Reference: integer arithmetic on effective operands; overflow from signed range.
  function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic sub);
    longint m, half, xv, yv, ce, tot, low, sx, sy, sr;
    logic [17:0] r;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    xv   = longint'(x) & m;
    yv   = longint'(y) & m;
    if (sub) yv = (~yv) & m;
    ce   = (c ^ sub) ? 1 : 0;
    tot  = xv + yv + ce;
    low  = tot & m;
    sx   = (xv >= half) ? xv - 2 * half : xv;
    sy   = (yv >= half) ? yv - 2 * half : yv;
    sr   = sx + sy + ce;
    r[15:0] = low[15:0];
    r[16]   = tot[w];
    r[17]   = (sr >= half) || (sr < -half);
    return r;
  endfunction

  function automatic void add_vec(input int s, input logic [15:0] x, input logic [15:0] y, input logic c,
                                  input logic sub, input logic [15:0] sum, input logic co, input logic ov);
    tbl.push_back('{s, x, y, c, sub, sum, co, ov});
  endfunction

  function automatic void add_model_vec(input int s, input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic sub);
    logic [17:0] e;
    e = model(width_of(s), x, y, c, sub);
    add_vec(s, x, y, c, sub, e[15:0], e[16], e[17]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    lat = lat_of(v.sel);
    @(negedge clk);
    sel = v.sel; in_x = v.x; in_y = v.y; in_c = v.c; in_sub = v.sub; drv_valid = 1'b1; out_rdy = 1'b1;
    #1;
    chk("accept_ready", act_ready, 1);
    chk("idle_valid", act_valid, 0);
    @(posedge clk);
    #1 drv_valid = 1'b0;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      chk("early_valid", act_valid, 0);
    end
    @(negedge clk);
    chk("vec_valid", act_valid, 1);
    chk("vec_sum", act_sum, v.sum);
    chk("vec_cout", act_cout, v.cout);
    chk("vec_ovf", act_ovf, v.ovf);
    @(negedge clk);
    chk("valid_once", act_valid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] bx[20], by[20];
    logic        bc[20], bs[20];
    int          sent, got;

    reset = 1'b1; drv_valid = 1'b0; out_rdy = 1'b1; sel = 0;
    in_x = 16'h0; in_y = 16'h0; in_c = 1'b0; in_sub = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sel = i;
      #1;
      chk("rst_valid", act_valid, 0);
      chk("rst_sum", act_sum, 0);
      chk("rst_cout", act_cout, 0);
      chk("rst_ovf", act_ovf, 0);
      chk("rst_ready", act_ready, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", act_ready, 1);

    // Full-adder truth table (x, y, c) -> sum, cout, ovf = c ^ cout
    add_vec(0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    add_vec(0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h1, 1'b0, 1'b1);
    add_vec(0, 16'h0, 16'h1, 1'b0, 1'b0, 16'h1, 1'b0, 1'b0);
    add_vec(0, 16'h0, 16'h1, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    add_vec(0, 16'h1, 16'h0, 1'b0, 1'b0, 16'h1, 1'b0, 1'b0);
    add_vec(0, 16'h1, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    add_vec(0, 16'h1, 16'h1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    add_vec(0, 16'h1, 16'h1, 1'b1, 1'b0, 16'h1, 1'b1, 1'b0);
    add_vec(1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    add_vec(1, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1);
    add_vec(2, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h00FE, 1'b0, 1'b0);
    add_vec(2, 16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1);
    add_vec(2, 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
    add_vec(3, 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    add_vec(3, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      add_model_vec(1 + (i % 3), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    foreach (tbl[i]) run_vec(tbl[i]);

    // Streaming 20 beats with a downstream stall in cycles 6..9
    for (int i = 0; i < 20; i++) begin
      bx[i] = 16'($urandom); by[i] = 16'($urandom); bc[i] = 1'($urandom); bs[i] = 1'($urandom);
    end
    sel = 3; sent = 0; got = 0;
    for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
      @(negedge clk);
      if (act_valid) begin
        if (exp_q.size() == 0) begin
          chk("stream_extra", act_valid, 0);
        end else begin
          chk("stream_sum", act_sum, exp_q[0][15:0]);
          chk("stream_cout", act_cout, exp_q[0][16]);
          chk("stream_ovf", act_ovf, exp_q[0][17]);
        end
      end
      out_rdy = !(cyc >= 6 && cyc <= 9);
      if (sent < 20) begin
        drv_valid = 1'b1; in_x = bx[sent]; in_y = by[sent]; in_c = bc[sent]; in_sub = bs[sent];
      end else begin
        drv_valid = 1'b0;
      end
      #1;
      if (cyc >= 6 && cyc <= 9) begin
        chk("stall_in_ready", act_ready, 0);
        chk("stall_out_valid", act_valid, 1);
      end
      if (drv_valid && act_ready) begin
        exp_q.push_back(model(16, bx[sent], by[sent], bc[sent], bs[sent]));
        sent++;
      end
      if (act_valid && out_rdy && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        got++;
      end
    end
    drv_valid = 1'b0; out_rdy = 1'b1;
    chk("stream_sent", sent, 20);
    chk("stream_got", got, 20);
    @(negedge clk);
    chk("stream_drained", act_valid, 0);

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drv_valid = 1'b1; in_x = 16'h1111 * 16'(i + 1); in_y = 16'h0101; in_c = 1'b0; in_sub = 1'b0;
    end
    @(negedge clk);
    drv_valid = 1'b0; reset = 1'b1;
    #1;
    chk("midrst_ready", act_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_valid", act_valid, 0);
    chk("midrst_sum", act_sum, 0);
    chk("midrst_cout", act_cout, 0);
    chk("midrst_ovf", act_ovf, 0);
    chk("midrst_in_ready", act_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_emit", act_valid, 0);
    end
    tbl.delete();
    add_model_vec(3, 16'h1234, 16'h0FED, 1'b1, 1'b0);
    run_vec(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
